// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared screen geometry, pixel field types and draw FSM states
package vga_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  typedef logic [7:0] x_t;
  typedef logic [6:0] y_t;
  typedef logic [2:0] colour_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_CIRC,
    ST_DONE
  } draw_state_t;

endpackage

// File: rtl/screen_clear_cnt.sv
// rtl/screen_clear_cnt.sv - column-major x/y frame counter with enable, clear and last-pixel flag
module screen_clear_cnt
  import vga_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       last
);

  localparam x_t X_LAST = x_t'(SCREEN_W - 1);
  localparam y_t Y_LAST = y_t'(SCREEN_H - 1);

  x_t   r_x;
  y_t   r_y;
  logic w_y_wrap;

  assign w_y_wrap = (r_y == Y_LAST);

  // y is the inner loop; x advances only when a column finishes
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (en) begin
      if (w_y_wrap) begin
        r_y <= '0;
        r_x <= (r_x == X_LAST) ? '0 : r_x + 8'd1;
      end else begin
        r_y <= r_y + 7'd1;
      end
    end
  end

  assign x    = r_x;
  assign y    = r_y;
  assign last = (r_x == X_LAST) && w_y_wrap;

endmodule

// File: rtl/circle_draw_ctrl.sv
// rtl/circle_draw_ctrl.sv - clears the frame, then launches circle and forwards its clipped pixel stream
module circle_draw_ctrl
  import vga_pkg::*;
#(
  parameter int         SCREEN_W     = SCREEN_W_DEF,
  parameter int         SCREEN_H     = SCREEN_H_DEF,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] colour,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] radius,
  output logic       done,
  output logic       circ_start,
  output logic [2:0] circ_colour,
  output logic [7:0] circ_centre_x,
  output logic [6:0] circ_centre_y,
  output logic [7:0] circ_radius,
  input  logic       circ_done,
  input  logic [7:0] circ_x,
  input  logic [6:0] circ_y,
  input  logic [2:0] circ_colour_in,
  input  logic       circ_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  localparam logic [8:0] W_LIM = 9'(SCREEN_W);
  localparam logic [7:0] H_LIM = 8'(SCREEN_H);

  draw_state_t r_state;
  draw_state_t w_next;

  x_t      r_centre_x;
  y_t      r_centre_y;
  x_t      r_radius;
  colour_t r_colour;

  logic [7:0] w_cnt_x;
  logic [6:0] w_cnt_y;
  logic       w_cnt_last;
  logic       w_cnt_en;
  logic       w_cnt_clr;
  logic       w_in_bounds;

  screen_clear_cnt #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_clear_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_cnt_en),
    .clr   (w_cnt_clr),
    .x     (w_cnt_x),
    .y     (w_cnt_y),
    .last  (w_cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Parameters are captured only on acceptance so later input changes cannot disturb a run
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_centre_x <= '0;
      r_centre_y <= '0;
      r_radius   <= '0;
      r_colour   <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_centre_x <= centre_x;
      r_centre_y <= centre_y;
      r_radius   <= radius;
      r_colour   <= colour;
    end
  end

  assign circ_centre_x = r_centre_x;
  assign circ_centre_y = r_centre_y;
  assign circ_radius   = r_radius;
  assign circ_colour   = r_colour;

  assign w_in_bounds = ({1'b0, circ_x} < W_LIM) && ({1'b0, circ_y} < H_LIM);

  always_comb begin
    w_next     = r_state;
    done       = 1'b0;
    circ_start = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    w_cnt_en   = 1'b0;
    w_cnt_clr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_clr = 1'b1;
        if (start) w_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        w_cnt_en   = 1'b1;
        vga_x      = w_cnt_x;
        vga_y      = w_cnt_y;
        vga_colour = CLEAR_COLOUR;
        vga_plot   = 1'b1;
        if (w_cnt_last) w_next = ST_CIRC;
      end
      ST_CIRC: begin
        circ_start = 1'b1;
        vga_x      = circ_x;
        vga_y      = circ_y;
        vga_colour = circ_colour_in;
        vga_plot   = circ_plot && w_in_bounds;
        if (circ_done) w_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (!start) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_circle_draw_ctrl.sv
// tb/tb_circle_draw_ctrl.sv - scoreboard bench for circle_draw_ctrl with a queue-based pixel model
module tb_circle_draw_ctrl;
  import vga_pkg::*;

  localparam int         W     = 160;
  localparam int         H     = 120;
  localparam logic [2:0] CLR_C = 3'b000;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] colour;
  logic [7:0] centre_x;
  logic [6:0] centre_y;
  logic [7:0] radius;
  logic       done;
  logic       circ_start;
  logic [2:0] circ_colour;
  logic [7:0] circ_centre_x;
  logic [6:0] circ_centre_y;
  logic [7:0] circ_radius;
  logic       circ_done;
  logic [7:0] circ_x;
  logic [6:0] circ_y;
  logic [2:0] circ_colour_in;
  logic       circ_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  pix_t exp_q[$];
  pix_t e_pix;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  circle_draw_ctrl #(
    .SCREEN_W     (W),
    .SCREEN_H     (H),
    .CLEAR_COLOUR (CLR_C)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .colour         (colour),
    .centre_x       (centre_x),
    .centre_y       (centre_y),
    .radius         (radius),
    .done           (done),
    .circ_start     (circ_start),
    .circ_colour    (circ_colour),
    .circ_centre_x  (circ_centre_x),
    .circ_centre_y  (circ_centre_y),
    .circ_radius    (circ_radius),
    .circ_done      (circ_done),
    .circ_x         (circ_x),
    .circ_y         (circ_y),
    .circ_colour_in (circ_colour_in),
    .circ_plot      (circ_plot),
    .vga_x          (vga_x),
    .vga_y          (vga_y),
    .vga_colour     (vga_colour),
    .vga_plot       (vga_plot)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every pixel of the frame, column by column, in the clear colour
  task automatic push_clear();
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        exp_q.push_back('{x: 8'(x), y: 7'(y), c: CLR_C});
  endtask

  always @(negedge clk) begin
    if (vga_plot === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_plot", 1, 0);
      end else begin
        e_pix = exp_q.pop_front();
        check("pix_x", int'(vga_x), int'(e_pix.x));
        check("pix_y", int'(vga_y), int'(e_pix.y));
        check("pix_colour", int'(vga_colour), int'(e_pix.c));
      end
    end
  end

  task automatic run_draw(input logic [7:0] cx, input logic [6:0] cy, input logic [7:0] rad,
                          input logic [2:0] col, input int n_circ, input bit drop);
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
    logic       pp;
    centre_x = cx;
    centre_y = cy;
    radius   = rad;
    colour   = col;
    start    = 1'b1;
    push_clear();
    tick();
    for (int i = 1; i < W * H; i++) begin
      if (i == 100) begin
        centre_x = drop ? 8'd5 : ~cx;
        centre_y = ~cy;
        radius   = ~rad;
        colour   = ~col;
        if (drop) start = 1'b0;
      end
      circ_x         = 8'($urandom);
      circ_y         = 7'($urandom);
      circ_colour_in = 3'($urandom);
      circ_plot      = 1'b1;
      tick();
    end
    circ_plot = 1'b0;
    check("circ_start_early", int'(circ_start), 0);
    tick();
    check("circ_start_on", int'(circ_start), 1);
    check("circ_centre_x", int'(circ_centre_x), int'(cx));
    check("circ_centre_y", int'(circ_centre_y), int'(cy));
    check("circ_radius", int'(circ_radius), int'(rad));
    check("circ_colour", int'(circ_colour), int'(col));
    for (int j = 0; j < n_circ; j++) begin
      case (j)
        0:       begin px = 8'd170; py = 7'd10;  end
        1:       begin px = 8'd10;  py = 7'd125; end
        2:       begin px = 8'd159; py = 7'd119; end
        3:       begin px = 8'd160; py = 7'd119; end
        4:       begin px = 8'd159; py = 7'd120; end
        default: begin px = 8'($urandom_range(0, 179)); py = 7'($urandom_range(0, 127)); end
      endcase
      pc = 3'($urandom);
      pp = (j < 5) ? 1'b1 : 1'($urandom);
      circ_x         = px;
      circ_y         = py;
      circ_colour_in = pc;
      circ_plot      = pp;
      if (pp && int'(px) < W && int'(py) < H)
        exp_q.push_back('{x: px, y: py, c: pc});
      #1;
      if (j < 5) check("clip_plot", int'(vga_plot), (j == 2) ? 1 : 0);
      tick();
    end
    circ_plot = 1'b0;
    circ_done = 1'b1;
    tick();
    circ_done = 1'b0;
    check("done_rise", int'(done), 1);
    check("circ_start_off", int'(circ_start), 0);
    if (drop) begin
      tick();
      check("done_pulse_end", int'(done), 0);
    end else begin
      repeat (3) begin
        tick();
        check("done_hold", int'(done), 1);
      end
      start = 1'b0;
      tick();
      check("done_release", int'(done), 0);
    end
  endtask

  task automatic run_abort();
    centre_x = 8'($urandom);
    centre_y = 7'($urandom);
    radius   = 8'($urandom);
    colour   = 3'($urandom);
    start    = 1'b1;
    push_clear();
    tick();
    repeat (5000) tick();
    check("abort_at_x", int'(vga_x), 5000 / H);
    check("abort_at_y", int'(vga_y), 5000 % H);
    rst_n = 1'b0;
    start = 1'b0;
    tick();
    exp_q.delete();
    check("abort_plot", int'(vga_plot), 0);
    check("abort_circ_start", int'(circ_start), 0);
    check("abort_done", int'(done), 0);
    rst_n = 1'b1;
    tick();
    check("abort_idle_plot", int'(vga_plot), 0);
  endtask

  initial begin
    bit seen_done;
    rst_n          = 1'b0;
    start          = 1'b0;
    colour         = '0;
    centre_x       = '0;
    centre_y       = '0;
    radius         = '0;
    circ_done      = 1'b0;
    circ_x         = '0;
    circ_y         = '0;
    circ_colour_in = '0;
    circ_plot      = 1'b0;
    repeat (3) tick();
    check("rst_done", int'(done), 0);
    check("rst_circ_start", int'(circ_start), 0);
    check("rst_vga_plot", int'(vga_plot), 0);
    check("rst_vga_x", int'(vga_x), 0);
    check("rst_vga_y", int'(vga_y), 0);
    check("rst_vga_colour", int'(vga_colour), 0);
    check("rst_circ_centre_x", int'(circ_centre_x), 0);
    check("rst_circ_radius", int'(circ_radius), 0);
    rst_n     = 1'b1;
    seen_done = 1'b0;
    repeat (100) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    check("idle_no_done", int'(seen_done), 0);

    run_draw(8'd80, 7'd60, 8'd40, 3'b010, 200, 1'b1);
    run_abort();
    run_draw(8'($urandom), 7'($urandom), 8'($urandom), 3'($urandom), $urandom_range(20, 120), 1'b0);
    run_draw(8'($urandom), 7'($urandom), 8'd0, 3'($urandom), $urandom_range(20, 120), 1'b0);

    repeat (2) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
